// File: rtl/trig_ascii_formatter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trig_ascii_formatter_pkg
// Purpose  : Shared constants and types for the CORDIC result ASCII formatter.
//            Holds the fixed-point operand layout, the ASCII characters used
//            to build a line, the formatter state encoding and a digit helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package trig_ascii_formatter_pkg;

    // Operand layout: signed 42-bit, [40:34] integer, [33:0] fraction
    localparam int FRAC_W = 34;
    localparam int DATA_W = 42;
    localparam int INT_W  = DATA_W - FRAC_W - 1;

    localparam logic [7:0] ASCII_0   = 8'h30;
    localparam logic [7:0] ASCII_9   = 8'h39;
    localparam logic [7:0] ASCII_S   = 8'h53;
    localparam logic [7:0] ASCII_C   = 8'h43;
    localparam logic [7:0] ASCII_EQ  = 8'h3D;
    localparam logic [7:0] ASCII_DOT = 8'h2E;
    localparam logic [7:0] ASCII_SP  = 8'h20;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // Decimal digit 0..9 to its ASCII character
    function automatic logic [7:0] digit_to_ascii(input logic [3:0] digit);
        return ASCII_0 + {4'h0, digit};
    endfunction

endpackage
`default_nettype wire

// File: rtl/trig_ascii_formatter_frac_digit_gen.sv
`default_nettype none
// ============================================================================
// Module   : trig_ascii_formatter_frac_digit_gen
// Purpose  : One combinational decimal step of a binary fraction: multiplies
//            the fraction by ten; the carry-out nibble is the next decimal
//            digit and the low bits are the remaining fraction.
// Ports    : i_frac  [FRAC_W-1:0]  fraction in
//            o_digit [3:0]         decimal digit (0..9)
//            o_frac  [FRAC_W-1:0]  fraction remaining after the digit
// Revision : 1.0 - initial release
// ============================================================================
module trig_ascii_formatter_frac_digit_gen
    import trig_ascii_formatter_pkg::*;
(
    input  logic [FRAC_W-1:0] i_frac,
    output logic [3:0]        o_digit,
    output logic [FRAC_W-1:0] o_frac
);

    logic [FRAC_W+3:0] w_prod;

    // frac*10 = frac*8 + frac*2; always < 10*2^FRAC_W so 4 integer bits suffice
    always_comb begin
        w_prod  = {1'b0, i_frac, 3'b000} + {3'b000, i_frac, 1'b0};
        o_digit = w_prod[FRAC_W+3:FRAC_W];
        o_frac  = w_prod[FRAC_W-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/trig_ascii_formatter.sv
`default_nettype none
// ============================================================================
// Module   : trig_ascii_formatter
// Purpose  : Captures a CORDIC Sin/Cos result on its done pulse and streams it
//            to a UART transmitter as "S=d.ddd.. C=d.ddd..\r\n", one byte per
//            valid/ready handshake. Decimal digits are produced on the fly as
//            each byte is loaded, so there are no conversion stall cycles.
// Ports    : clk, rst_n         clock, synchronous active-low reset
//            start_to_UART      result-valid pulse, samples Sin/Cos in IDLE
//            Sin, Cos [41:0]    signed fixed point, 34 fractional bits
//            tx_data [7:0]      ASCII byte, tx_valid / tx_ready handshake
//            busy               a line is being emitted
//            overrun            1-cycle pulse, start dropped while busy
// Revision : 1.0 - initial release
// ============================================================================
module trig_ascii_formatter
    import trig_ascii_formatter_pkg::*;
#(
    parameter int FRAC_DIGITS = 8   // 1..12
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_to_UART,
    input  logic [DATA_W-1:0] Sin,
    input  logic [DATA_W-1:0] Cos,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              overrun
);

    localparam int LINE_LEN = 2 * (FRAC_DIGITS + 4) + 3;
    localparam int IDX_W    = $clog2(LINE_LEN);

    // Byte positions within the line
    localparam logic [IDX_W-1:0] P_S_EQ    = IDX_W'(1);
    localparam logic [IDX_W-1:0] P_S_INT   = IDX_W'(2);
    localparam logic [IDX_W-1:0] P_S_DOT   = IDX_W'(3);
    localparam logic [IDX_W-1:0] P_S_FRAC0 = IDX_W'(4);
    localparam logic [IDX_W-1:0] P_SP      = IDX_W'(4 + FRAC_DIGITS);
    localparam logic [IDX_W-1:0] P_C       = IDX_W'(5 + FRAC_DIGITS);
    localparam logic [IDX_W-1:0] P_C_EQ    = IDX_W'(6 + FRAC_DIGITS);
    localparam logic [IDX_W-1:0] P_C_INT   = IDX_W'(7 + FRAC_DIGITS);
    localparam logic [IDX_W-1:0] P_C_DOT   = IDX_W'(8 + FRAC_DIGITS);
    localparam logic [IDX_W-1:0] P_C_FRAC0 = IDX_W'(9 + FRAC_DIGITS);
    localparam logic [IDX_W-1:0] P_CR      = IDX_W'(9 + 2 * FRAC_DIGITS);
    localparam logic [IDX_W-1:0] P_LF      = IDX_W'(10 + 2 * FRAC_DIGITS);

    state_t              state_q,    state_d;
    logic [IDX_W-1:0]    idx_q,      idx_d;
    logic [7:0]          tx_data_q,  tx_data_d;
    logic [FRAC_W-1:0]   sin_frac_q, sin_frac_d;
    logic [FRAC_W-1:0]   cos_frac_q, cos_frac_d;
    logic [3:0]          sin_int_q,  sin_int_d;
    logic [3:0]          cos_int_q,  cos_int_d;
    logic                sin_sat_q,  sin_sat_d;
    logic                cos_sat_q,  cos_sat_d;
    logic                overrun_q,  overrun_d;

    logic [INT_W-1:0]    w_sin_int;
    logic [INT_W-1:0]    w_cos_int;
    logic                w_sin_sat;
    logic                w_cos_sat;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic                w_gen_sel_sin;
    logic [FRAC_W-1:0]   w_gen_frac_in;
    logic [3:0]          w_gen_digit;
    logic [FRAC_W-1:0]   w_gen_frac_out;
    logic [7:0]          w_next_byte;
    logic                w_step_sin;
    logic                w_step_cos;
    logic                w_unused_sign;

    // The sign bit carries no information for the printed magnitude
    assign w_unused_sign = Sin[DATA_W-1] ^ Cos[DATA_W-1];

    assign w_sin_int = Sin[DATA_W-2:FRAC_W];
    assign w_cos_int = Cos[DATA_W-2:FRAC_W];
    assign w_sin_sat = (w_sin_int > INT_W'(9));
    assign w_cos_sat = (w_cos_int > INT_W'(9));

    assign w_idx_nxt = idx_q + 1'b1;

    // Single digit generator shared by both values: the next byte belongs to
    // the Sin half whenever it lies before the separating space.
    assign w_gen_sel_sin = (w_idx_nxt < P_SP);
    assign w_gen_frac_in = w_gen_sel_sin ? sin_frac_q : cos_frac_q;

    trig_ascii_formatter_frac_digit_gen u_frac_digit_gen (
        .i_frac  (w_gen_frac_in),
        .o_digit (w_gen_digit),
        .o_frac  (w_gen_frac_out)
    );

    // Byte to present after the current one is accepted
    always_comb begin
        w_next_byte = 8'h00;
        w_step_sin  = 1'b0;
        w_step_cos  = 1'b0;
        case (w_idx_nxt)
            P_S_EQ, P_C_EQ: w_next_byte = ASCII_EQ;
            P_S_DOT, P_C_DOT: w_next_byte = ASCII_DOT;
            P_S_INT: w_next_byte = digit_to_ascii(sin_int_q);
            P_C_INT: w_next_byte = digit_to_ascii(cos_int_q);
            P_SP:    w_next_byte = ASCII_SP;
            P_C:     w_next_byte = ASCII_C;
            P_CR:    w_next_byte = ASCII_CR;
            P_LF:    w_next_byte = ASCII_LF;
            default: begin
                if ((w_idx_nxt >= P_S_FRAC0) && (w_idx_nxt < P_SP)) begin
                    w_step_sin  = 1'b1;
                    w_next_byte = sin_sat_q ? ASCII_9 : digit_to_ascii(w_gen_digit);
                end else if ((w_idx_nxt >= P_C_FRAC0) && (w_idx_nxt < P_CR)) begin
                    w_step_cos  = 1'b1;
                    w_next_byte = cos_sat_q ? ASCII_9 : digit_to_ascii(w_gen_digit);
                end
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tx_data_d  = tx_data_q;
        sin_frac_d = sin_frac_q;
        cos_frac_d = cos_frac_q;
        sin_int_d  = sin_int_q;
        cos_int_d  = cos_int_q;
        sin_sat_d  = sin_sat_q;
        cos_sat_d  = cos_sat_q;
        overrun_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_to_UART) begin
                    sin_frac_d = Sin[FRAC_W-1:0];
                    cos_frac_d = Cos[FRAC_W-1:0];
                    sin_sat_d  = w_sin_sat;
                    cos_sat_d  = w_cos_sat;
                    sin_int_d  = w_sin_sat ? 4'd9 : w_sin_int[3:0];
                    cos_int_d  = w_cos_sat ? 4'd9 : w_cos_int[3:0];
                    tx_data_d  = ASCII_S;
                    idx_d      = '0;
                    state_d    = ST_EMIT;
                end
            end
            ST_EMIT: begin
                // Any start while a line is in flight is dropped, including
                // on the final handshake cycle.
                overrun_d = start_to_UART;
                if (tx_ready) begin
                    if (idx_q == P_LF) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d     = w_idx_nxt;
                        tx_data_d = w_next_byte;
                        if (w_step_sin) sin_frac_d = w_gen_frac_out;
                        if (w_step_cos) cos_frac_d = w_gen_frac_out;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            tx_data_q  <= 8'h00;
            sin_frac_q <= '0;
            cos_frac_q <= '0;
            sin_int_q  <= 4'd0;
            cos_int_q  <= 4'd0;
            sin_sat_q  <= 1'b0;
            cos_sat_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            sin_frac_q <= sin_frac_d;
            cos_frac_q <= cos_frac_d;
            sin_int_q  <= sin_int_d;
            cos_int_q  <= cos_int_d;
            sin_sat_q  <= sin_sat_d;
            cos_sat_q  <= cos_sat_d;
            overrun_q  <= overrun_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = (state_q == ST_EMIT);
    assign busy     = (state_q == ST_EMIT);
    assign overrun  = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_trig_ascii_formatter.sv
`default_nettype none
// ============================================================================
// Module   : tb_trig_ascii_formatter
// Purpose  : Self-checking bench for trig_ascii_formatter. The driver pushes
//            the expected ASCII line into a queue when it issues a start; a
//            monitor pops and compares on every accepted byte and also checks
//            that tx_data holds steady while stalled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trig_ascii_formatter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_to_UART;
    logic [41:0] Sin;
    logic [41:0] Cos;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        overrun;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  exp_q[$];

    localparam logic [41:0] V_HALF  = 42'd8589934592;    // 0.5
    localparam logic [41:0] V_COS30 = 42'd14878203148;   // 0.8660254037...
    localparam logic [41:0] V_ONE   = 42'd17179869184;   // 1.0
    localparam logic [41:0] V_NINE  = 42'd154618822656;  // 9.0
    localparam logic [41:0] V_TEN   = 42'd171798691840;  // 10.0
    localparam logic [41:0] V_SIGN  = 42'h20000000000;   // bit 41

    always #5 clk = ~clk;

    trig_ascii_formatter #(.FRAC_DIGITS(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_to_UART (start_to_UART),
        .Sin           (Sin),
        .Cos           (Cos),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .busy          (busy),
        .overrun       (overrun)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_line(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    // Issue a one-cycle start with the given operands and expected line
    task automatic start_line(input logic [41:0] s_val, input logic [41:0] c_val, input string line);
        Sin = s_val;
        Cos = c_val;
        push_line(line);
        start_to_UART = 1'b1;
        step();
        start_to_UART = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 400) begin
            cyc++;
            step();
        end
        if (busy) check("wait_idle_timeout", 64'(busy), 64'd0);
    endtask

    // Monitor: compare each accepted byte, and stall stability
    initial begin : p_monitor
        logic [7:0] held_data;
        logic       held;
        logic [7:0] exp_b;
        held = 1'b0;
        held_data = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx_valid === 1'b1) begin
                if (held) check("stall_hold", 64'(tx_data), 64'(held_data));
                if (tx_ready === 1'b1) begin
                    held = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got %02h expected none at %0t", tx_data, $time);
                    end else begin
                        exp_b = exp_q.pop_front();
                        check("byte", 64'(tx_data), 64'(exp_b));
                    end
                end else begin
                    held = 1'b1;
                    held_data = tx_data;
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin : p_watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : p_driver
        int cyc;
        rst_n = 1'b0;
        start_to_UART = 1'b0;
        Sin = '0;
        Cos = '0;
        tx_ready = 1'b0;
        repeat (3) step();
        check("rst_tx_data", 64'(tx_data), 64'h00);
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        rst_n = 1'b1;
        step();

        // Nominal line, full throughput
        tx_ready = 1'b1;
        start_line(V_HALF, V_COS30, "S=0.50000000 C=0.86602540\r\n");
        check("first_valid", 64'(tx_valid), 64'd1);
        check("first_byte_S", 64'(tx_data), 64'h53);
        wait_idle(cyc);
        check("busy_cycles", 64'(cyc), 64'd27);

        start_line(42'd0, V_ONE, "S=0.00000000 C=1.00000000\r\n");
        wait_idle(cyc);

        // Saturation on Cos; sign bit on Sin ignored
        start_line(V_SIGN | V_HALF, V_TEN, "S=0.50000000 C=9.99999999\r\n");
        wait_idle(cyc);

        // Largest unsaturated integer
        start_line(V_NINE, 42'd0, "S=9.00000000 C=0.00000000\r\n");
        wait_idle(cyc);

        // Backpressure: 1010... with a 5-cycle hold low mid-digit
        start_line(V_HALF, V_COS30, "S=0.50000000 C=0.86602540\r\n");
        cyc = 0;
        while (busy && cyc < 400) begin
            tx_ready = (cyc >= 8 && cyc < 13) ? 1'b0 : ((cyc % 2) == 0);
            step();
            cyc++;
        end
        check("bp_done", 64'(busy), 64'd0);
        tx_ready = 1'b1;
        step();

        // Overrun mid-line
        start_line(42'd0, V_ONE, "S=0.00000000 C=1.00000000\r\n");
        repeat (9) step();
        Sin = V_TEN;
        Cos = V_TEN;
        start_to_UART = 1'b1;
        step();
        start_to_UART = 1'b0;
        check("overrun_pulse", 64'(overrun), 64'd1);
        check("overrun_busy", 64'(busy), 64'd1);
        step();
        check("overrun_clear", 64'(overrun), 64'd0);
        wait_idle(cyc);
        repeat (10) step();
        check("no_second_line", 64'(busy), 64'd0);

        // Start held for three cycles: one line, two overrun pulses
        Sin = V_HALF;
        Cos = V_COS30;
        push_line("S=0.50000000 C=0.86602540\r\n");
        start_to_UART = 1'b1;
        step();
        check("held_start_ovr0", 64'(overrun), 64'd0);
        step();
        check("held_start_ovr1", 64'(overrun), 64'd1);
        step();
        check("held_start_ovr2", 64'(overrun), 64'd1);
        start_to_UART = 1'b0;
        step();
        check("held_start_ovr3", 64'(overrun), 64'd0);
        wait_idle(cyc);
        step();

        // Reset in the middle of a line
        start_line(V_HALF, V_COS30, "S=0.50000000 C=0.86602540\r\n");
        repeat (14) step();
        rst_n = 1'b0;
        step();
        check("mid_rst_valid", 64'(tx_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_data", 64'(tx_data), 64'h00);
        exp_q.delete();
        rst_n = 1'b1;
        step();
        start_line(42'd0, V_ONE, "S=0.00000000 C=1.00000000\r\n");
        check("post_rst_S", 64'(tx_data), 64'h53);
        wait_idle(cyc);
        check("post_rst_cycles", 64'(cyc), 64'd27);

        repeat (5) step();
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
